// File: rtl/time_display_scan.sv
// Scans an 18-bit HH:MM:SS time word onto a six-digit common-anode display.
// The time word is snapshotted once per frame so the digits never tear.
module time_display_scan #(
  parameter int SCAN_DIV  = 2,
  parameter int BLINK_DIV = 250
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [17:0] TIME_DATA,
  input  logic        EDIT_EN,
  input  logic [1:0]  EDIT_FIELD,
  output logic [7:0]  SEG,
  output logic [5:0]  DIGIT_SEL,
  output logic        FRAME_DONE
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic [17:0]   snap_q, snap_d, snap_v;
  logic          first_q, edit_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    seg_q, seg_d;
  logic [5:0]    sel_q, sel_d;
  logic          scan_tc, wrap, rise, blank, in_range;
  logic [5:0]    val;
  logic [3:0]    bcd;
  logic [7:0]    code;

  assign scan_tc    = scan_q == SCAN_TC;
  assign wrap       = scan_tc && idx_q == 3'd5;
  assign rise       = EDIT_EN && !edit_q;
  assign FRAME_DONE = wrap;
  assign SEG        = seg_q;
  assign DIGIT_SEL  = sel_q;

  always_comb begin
    scan_d = scan_tc ? '0 : scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_tc)
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    snap_d  = (first_q || wrap) ? TIME_DATA : snap_q;
    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (rise) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BLINK_TC) begin
      bcnt_d  = '0;
      phase_d = !phase_q;
    end
  end

  // The first frame after reset decodes straight from the bus.
  always_comb begin
    snap_v = first_q ? TIME_DATA : snap_q;
    unique case (idx_q[2:1])
      2'd0:    val = snap_v[5:0];
      2'd1:    val = snap_v[11:6];
      default: val = snap_v[17:12];
    endcase
    in_range = (idx_q[2:1] == 2'd2) ? (val < 6'd24) : (val < 6'd60);
    bcd = idx_q[0] ? 4'(val / 6'd10) : 4'(val % 6'd10);
    unique case (bcd)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    blank = EDIT_EN && !rise && phase_q
         && (EDIT_FIELD == idx_q[2:1]);
    seg_d = in_range ? code : 8'hBF;
    if (idx_q == 3'd2 || idx_q == 3'd4)
      seg_d[7] = 1'b0;
    if (blank)
      seg_d = 8'hFF;
    sel_d = ~(6'b1 << idx_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_q  <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 18'd0;
      first_q <= 1'b1;
      edit_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      seg_q   <= 8'hFF;
      sel_q   <= 6'h3F;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      first_q <= 1'b0;
      edit_q  <= EDIT_EN;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: cycle scoreboard plus directed display checks.
// A second instance covers the single-cycle scan rate.
module tb_time_display_scan;
  localparam int MS = 2;
  localparam int MB = 4;
  localparam logic [79:0] PATS = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                  8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] td  = 18'd0;
  logic        en  = 1'b0;
  logic [1:0]  fld = 2'd3;
  logic [7:0]  seg, one_seg;
  logic [5:0]  sel, one_sel;
  logic        fd, one_fd;

  int n_chk  = 0;
  int n_pass = 0;

  time_display_scan #(.SCAN_DIV(MS), .BLINK_DIV(MB)) u_dut (
    .CLK(clk), .RESET(rst), .TIME_DATA(td), .EDIT_EN(en),
    .EDIT_FIELD(fld), .SEG(seg), .DIGIT_SEL(sel), .FRAME_DONE(fd)
  );

  time_display_scan #(.SCAN_DIV(1), .BLINK_DIV(MB)) u_one (
    .CLK(clk), .RESET(rst), .TIME_DATA(td), .EDIT_EN(en),
    .EDIT_FIELD(fld), .SEG(one_seg), .DIGIT_SEL(one_sel),
    .FRAME_DONE(one_fd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [7:0] exp_digit(input logic [17:0] t,
                                           input int d);
    int v, lim, n;
    logic [7:0] s;
    v   = int'((t >> (6 * (d / 2))) & 18'h3F);
    lim = (d >= 4) ? 24 : 60;
    if (v >= lim) s = 8'hBF;
    else begin
      n = (d % 2 == 1) ? v / 10 : v % 10;
      s = PATS[n*8 +: 8];
    end
    if (d == 2 || d == 4) s[7] = 1'b0;
    return s;
  endfunction

  // Reference model of the SCAN_DIV=2 instance
  logic [14:0] sb[$];
  int          m_scan, m_idx, m_cnt;
  logic [17:0] m_snap, t;
  logic        m_first, m_ph, m_ed, e_fd;
  logic [7:0]  e_seg;
  logic [5:0]  e_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_scan = 0; m_idx = 0; m_cnt = 0; m_snap = 0;
      m_first = 1; m_ph = 0; m_ed = 0;
      e_seg = 8'hFF; e_sel = 6'h3F; e_fd = 0;
    end else begin
      t     = m_first ? td : m_snap;
      e_sel = 6'h3F ^ (6'b1 << m_idx);
      e_seg = exp_digit(t, m_idx);
      if (en && m_ed && m_ph && int'(fld) == m_idx / 2)
        e_seg = 8'hFF;
      if ((m_idx == 5 && m_scan == MS - 1) || m_first) m_snap = td;
      m_first = 0;
      if (m_scan == MS - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 6;
      end else m_scan++;
      if (en && !m_ed) begin
        m_cnt = 0; m_ph = 0;
      end else if (m_cnt == MB - 1) begin
        m_cnt = 0; m_ph = !m_ph;
      end else m_cnt++;
      m_ed = en;
      e_fd = (m_idx == 5 && m_scan == MS - 1);
    end
    sb.push_back({e_seg, e_sel, e_fd});
  end

  always @(negedge clk) begin
    logic [14:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_seg", 32'(seg), 32'(e[14:7]));
      chk("sb_sel", 32'(sel), 32'(e[6:1]));
      chk("sb_fd", 32'(fd), 32'(e[0]));
    end
  end

  task automatic wait_sel(input logic [5:0] v);
    int n = 0;
    while (sel !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_sel", 32'(sel), 32'(v));
  endtask

  task automatic wait_fd();
    int n = 0;
    while (fd !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_fd", 32'(fd), 32'd1);
  endtask

  task automatic frame_chk(input string tag, input logic [47:0] exp);
    for (int k = 0; k < 6; k++) begin
      chk({tag, "_sel"}, 32'(sel), 32'(6'h3F ^ (6'b1 << k)));
      chk({tag, "_seg"}, 32'(seg), 32'(exp[k*8 +: 8]));
      repeat (MS) @(negedge clk);
    end
  endtask

  initial begin
    int n, nb23, nbo, p0, p1, nfd;
    logic [5:0] s[13];
    logic       f[13];
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_sel", 32'(sel), 32'h3F);
    chk("rst_fd", 32'(fd), 32'd0);
    td  = 18'h0C8B8;
    rst = 1'b0;
    wait_sel(6'b111110);
    frame_chk("t123456", {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82});

    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd !== 1'b1 && n < 50);
    chk("frame_period", n, 12);

    wait_sel(6'b110111);
    td = 18'd0;
    chk("tear_d3", 32'(seg), 32'hB0);
    repeat (MS) @(negedge clk);
    chk("tear_d4", 32'(seg), 32'h24);
    repeat (MS) @(negedge clk);
    chk("tear_d5", 32'(seg), 32'hF9);
    repeat (MS) @(negedge clk);
    frame_chk("zero", {8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0});

    td = {6'd7, 6'd60, 6'd5};
    wait_fd();
    wait_sel(6'b111110);
    frame_chk("range", {8'hC0, 8'h78, 8'hBF, 8'h3F, 8'hC0, 8'h92});

    td  = 18'h0C8B8;
    fld = 2'd1;
    en  = 1'b1;
    nb23 = 0; nbo = 0;
    repeat (64) begin
      @(negedge clk);
      if (seg == 8'hFF) begin
        if (sel == 6'b111011 || sel == 6'b110111) nb23++;
        else nbo++;
      end
    end
    chk("blink_other", nbo, 0);
    chk("blink_field", 32'(nb23 > 0), 1);
    fld = 2'd3;
    @(negedge clk);
    nbo = 0;
    repeat (40) begin
      @(negedge clk);
      if (seg == 8'hFF) nbo++;
    end
    chk("blink_none", nbo, 0);
    en = 1'b0;

    wait_sel(6'b101111);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_sel", 32'(sel), 32'h3F);
    td = {6'd1, 6'd2, 6'd3};
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (sel === 6'h3F && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("restart_sel", 32'(sel), 32'h3E);
    chk("restart_seg", 32'(seg), 32'hB0);

    for (int i = 0; i < 13; i++) begin
      s[i] = one_sel;
      f[i] = one_fd;
      @(negedge clk);
    end
    nfd = 0; p0 = -1; p1 = -1;
    for (int i = 0; i < 12; i++) begin
      chk("one_hot", $countones(~s[i]), 1);
      chk("one_step", 32'(s[i+1]), 32'({s[i][4:0], s[i][5]}));
      if (f[i]) begin
        nfd++;
        if (p0 < 0) p0 = i;
        else if (p1 < 0) p1 = i;
      end
    end
    chk("one_fd_cnt", nfd, 2);
    chk("one_fd_gap", p1 - p0, 6);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Reader side of the 18-bit time bus: consumes the live time word from the seconds counter and drives a 6-digit multiplexed common-anode 7-segment display as HH.MM.SS.
- Latches the time word once per scan frame so digits never tear.
- Blinks the field being edited while the time-set logic is active.
- Sits between the RTC counter output and the board display pins.

Parameters:
- SCAN_DIV, 2: CLK cycles each digit is held before advancing (≥1).
- BLINK_DIV, 250: CLK cycles per blink half-period (≥1).

Ports:
- CLK  in  1  system clock (1 kHz on board)
- RESET  in  1  synchronous, active-high reset
- TIME_DATA  in  18  [17:12] hours, [11:6] minutes, [5:0] seconds, binary
- EDIT_EN  in  1  time-set mode active
- EDIT_FIELD  in  2  0 = seconds, 1 = minutes, 2 = hours, 3 = none
- SEG  out  8  active-low; [7] = dp, [6:0] = g..a
- DIGIT_SEL  out  6  active-low one-hot; bit 0 = rightmost (seconds ones)
- FRAME_DONE  out  1  one-cycle pulse when digit 5 finishes its slot

Behaviour:
- Reset (synchronous, RESET = 1 at a CLK edge):
  - SEG = 8'hFF, DIGIT_SEL = 6'b111111, FRAME_DONE = 0.
  - Snapshot = 0, digit index = 0, scan counter = 0, blink counter = 0, blink phase = 0.
  - RESET overrides all other inputs, including mid-frame.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - At the terminal count, digit index advances 0→1→…→5→0.
- Snapshot: loads TIME_DATA on the cycle the index wraps 5→0, and on the first cycle after RESET deasserts. TIME_DATA is ignored at all other times.
- FRAME_DONE: asserted for exactly the cycle in which index 5 reaches its terminal count.
- Digit mapping:
  - Digits 0/1 = seconds ones/tens.
  - Digits 2/3 = minutes ones/tens.
  - Digits 4/5 = hours ones/tens.
- Decimal point: lit (SEG[7] = 0) on digits 2 and 4 only.
- BCD conversion: tens = v/10, ones = v%10.
  - Valid ranges: seconds and minutes 0–59, hours 0–23.
  - Out-of-range field: both digits of that field show a dash (g only, 0xBF; 0x3F where dp is lit).
- Segment codes (dp off):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
- Blink:
  - Blink counter counts 0..BLINK_DIV-1; at the terminal count it wraps and toggles blink phase.
  - On the cycle EDIT_EN rises (0→1), both blink counter and phase clear, so each edit starts visible.
  - When EDIT_EN = 1, EDIT_FIELD selects the current digit's field, and phase = 1: SEG = 8'hFF (blank, dp included).
  - DIGIT_SEL keeps scanning while blanked.
  - EDIT_FIELD = 3 or EDIT_EN = 0: no blanking.
- Latency and output timing:
  - SEG and DIGIT_SEL are registered: they reflect the index, snapshot and blink phase of the previous cycle (1-cycle latency).
  - Exactly one DIGIT_SEL bit is low at all times outside reset.
- Simultaneous events:
  - Snapshot load and EDIT_EN rise in the same cycle: both take effect.
  - EDIT_FIELD change mid-digit: takes effect on the next registered output.

Test Plan:
- Reset then TIME_DATA = 18'h0C8B8 (12:34:56), SCAN_DIV = 2:
  - Digits 0..5 present SEG = 82, 92, 19, B0, 24, F9 respectively, with DIGIT_SEL = 111110…011111.
  - Each digit is held 2 cycles.
  - FRAME_DONE pulses once every 12 cycles.
- Tearing check: change TIME_DATA to 00:00:00 while index = 3:
  - Digits 3–5 of the current frame still show 3, 2., 1.
  - The next frame shows C0 / 40 (dp lit) for all digits.
- Out-of-range: TIME_DATA minutes = 60, seconds = 5, hours = 7:
  - Digit 3 = BF, digit 2 = 3F.
  - Digits 0/1 = 92/C0, digits 4/5 = 78/C0.
- Blink, BLINK_DIV = 4, EDIT_EN 0→1 with EDIT_FIELD = 1:
  - Digits 2/3 visible for 4 cycles, then SEG = FF on those digits for 4 cycles, repeating.
  - Other digits are never blanked.
  - EDIT_FIELD = 3 → no blanking.
- Reset mid-scan (index = 4): one cycle later SEG = FF and DIGIT_SEL = 111111; after release, scan restarts at digit 0 with a fresh snapshot.
- SCAN_DIV = 1: digit advances every cycle and FRAME_DONE pulses every 6 cycles with no skipped digit.
